// File: rtl/casc_up_counter.sv
// Loadable, cascadable modulo-N binary up-counter slice with ripple carry,
// wrap pulse (registered or combinational) and a sticky out-of-range load flag.
module casc_up_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16,
   parameter bit TC_REG  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_n,
   input  logic             load_n,
   input  logic [WIDTH-1:0] din,
   input  logic             enp,
   input  logic             ent,
   output logic [WIDTH-1:0] q,
   output logic             rco,
   output logic             wrap_pulse,
   output logic             load_err
);
   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
   // One extra bit so MODULUS == 2**WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic at_max;
   logic count_en;
   logic din_over;
   logic wrap_now;

   assign at_max   = (q == Q_MAX);
   assign count_en = enp & ent;
   assign din_over = ({1'b0, din} >= MOD_EXT);
   assign wrap_now = count_en & at_max & ~rst & clr_n & load_n;
   assign rco      = ent & at_max;

   always_ff @(posedge clk) begin
      if (rst) begin
         q        <= '0;
         load_err <= 1'b0;
      end else if (!clr_n) begin
         q <= '0;
      end else if (!load_n) begin
         if (din_over) begin
            q        <= Q_MAX;
            load_err <= 1'b1;
         end else begin
            q <= din;
         end
      end else if (count_en) begin
         q <= at_max ? '0 : q + WIDTH'(1);
      end
   end

   generate
      if (TC_REG) begin : g_wrap_reg
         logic wrap_q;
         always_ff @(posedge clk) begin
            if (rst) wrap_q <= 1'b0;
            else     wrap_q <= wrap_now;
         end
         assign wrap_pulse = wrap_q;
      end else begin : g_wrap_comb
         assign wrap_pulse = wrap_now;
      end
   endgenerate
endmodule

// File: doc/casc_up_counter.md
Name: casc_up_counter

Overview:
- Synchronous, loadable, cascadable binary up-counter slice.
- It counts in the opposite direction to the team's existing borrow-chain down-counter slice and mirrors its port style: parallel load data, two count enables, and a carry-out for chaining slices.
- It is used as the low or high slice of wider event/timer counters in the benchmark-derived control blocks.
- A programmable modulo limit lets one slice act as a divide-by-N prescaler.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- MODULUS, 16, count wraps to 0 after reaching MODULUS-1. Legal range 2..2**WIDTH.
- TC_REG, 1, 1 = the wrap_pulse output is registered (one cycle after the wrap); 0 = combinational with the wrap cycle.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- clr_n  input  1  synchronous clear, active-low; priority below rst
- load_n  input  1  synchronous parallel load, active-low
- din  input  WIDTH  parallel load value
- enp  input  1  count enable P (local)
- ent  input  1  count enable T (cascade; also gates rco)
- q  output  WIDTH  current count
- rco  output  1  ripple carry out: ent & (q == MODULUS-1), combinational
- wrap_pulse  output  1  one pulse per wrap from MODULUS-1 to 0
- load_err  output  1  sticky flag: a load was attempted with din >= MODULUS

Behaviour:
- Reset (rst=1 at a clock edge): q=0, wrap_pulse=0, load_err=0. rst has highest priority and overrides clr_n, load_n and the enables.
- Priority per edge: rst > clr_n=0 > load_n=0 > count > hold.
- Clear: when clr_n=0, q<=0. No wrap_pulse is generated. load_err is unchanged.
- Load: when load_n=0, q<=din, independent of enp/ent.
  - If din >= MODULUS, q<=MODULUS-1 (saturate) and load_err<=1.
  - load_err clears only on rst.
- Count: when enp=1 and ent=1:
  - if q == MODULUS-1: q<=0 (wrap);
  - otherwise: q<=q+1.
  - Arithmetic is WIDTH-bit unsigned and cannot overflow because of the modulo check.
- Hold: if either enable is 0, q is unchanged.
- rco:
  - Purely combinational; it does not depend on enp.
  - It asserts whenever ent=1 and q=MODULUS-1, and can assert during a hold.
  - Cascade wiring: the next slice's ent takes this slice's rco, and the next slice's enp takes the shared count enable.
- wrap_pulse:
  - A wrap event is a count operation taken at q=MODULUS-1.
  - TC_REG=1: wrap_pulse=1 for exactly the cycle after the wrap edge, i.e. while q is 0.
  - TC_REG=0: wrap_pulse = enp & ent & (q==MODULUS-1) & rst=0 & clr_n=1 & load_n=1, combinational in the wrap cycle.
  - A load or clear that sets q to 0 never produces wrap_pulse.
- Simultaneous events:
  - load_n=0 and a count condition in the same cycle: load wins and no wrap is flagged.
  - clr_n=0 and load_n=0 together: clear wins. load_err is still not updated, because no load occurs.
- Reset mid-count: any in-flight registered wrap_pulse is cancelled; wrap_pulse=0 in the cycle after rst.
- No X propagation: all state is explicitly reset. Unknown din is only sampled when load_n=0.

Test Plan:
- Reset and free run (WIDTH=4, MODULUS=16, TC_REG=1):
  - rst=1 for 2 cycles, then enp=ent=1 for 20 cycles.
  - q runs 0,1,…,15,0,1,2,3.
  - rco=1 only while q=15.
  - wrap_pulse=1 exactly in the cycle where q first returns to 0.
- Load and enable gating:
  - load_n=0 with din=9, then enp=1, ent=0 for 3 cycles, then enp=0, ent=1 at q=15 after loading 15.
  - q=9 holds for the 3 cycles.
  - After loading 15 with ent=1, rco=1 while enp=0 and q holds at 15.
- Modulo prescaler (MODULUS=10):
  - Count from 0 for 25 cycles.
  - Sequence 0..9,0..9,0..4.
  - Exactly 2 wrap_pulse assertions.
  - Loading din=12 gives q=9 and load_err=1; load_err persists until rst.
- Priority collisions:
  - At q=15 with enp=ent=1, assert load_n=0, din=3: q=3, no wrap_pulse.
  - Next cycle, assert clr_n=0 and load_n=0 with din=7: q=0, no wrap_pulse.
- Two-slice cascade (8-bit):
  - Low rco feeds the high ent; both enp tied high; count 300 cycles from 0.
  - The concatenated q equals cycle count mod 256 at every cycle (0x00..0xFF, then 0x00..0x2B).
  - The high slice's rco is high only at 0xFF.
- Reset mid-operation (TC_REG=1):
  - Assert rst on the same edge as a wrap from 15.
  - q=0 and wrap_pulse=0 in the following cycle.
  - Counting resumes normally from 0 after rst deasserts.
